imem_loader: RTL and testbench

Program loader that fills the instruction BRAM before the core runs. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word to consecutive word addresses through a single-cycle write strobe, and holds the core in reset until the final byte has been written. It is the write side of the instruction memory that the fetch stage reads.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction BRAM from a byte stream before the core runs.
// Bytes are packed little-endian into 32-bit words and written to consecutive
// word addresses; the core is held in reset until the last word lands.
// Optional feature macro: LOADER_CHECKSUM_EN (running sum of written words).
module imem_loader #(
   parameter int ADDR_WIDTH = 14,
   parameter int MAX_WORDS  = 16384
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [31:0]           wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  core_rst,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic [31:0]           checksum
);

   typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(MAX_WORDS);

   state_t      state;
   logic [1:0]  byte_idx;
   logic [31:0] asm_word;
   logic        last_word;
   logic [31:0] merged;
   logic        accept;
   logic        full;

   // Only the ready handshake is combinational: it follows state and reset directly.
   assign in_ready = ~rst & (state == S_LOAD);
   assign accept   = in_valid & in_ready;
   assign full     = (word_count == CAP);

   // Assembly register with the incoming byte dropped into its lane.
   always_comb begin
      merged = asm_word;
      merged[{byte_idx, 3'b000} +: 8] = in_data;
   end

   // Load sequencer: assemble bytes, emit one write strobe per word, then park in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_LOAD;
         we         <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         busy       <= 1'b1;
         done       <= 1'b0;
         core_rst   <= 1'b1;
         err        <= 1'b0;
         word_count <= '0;
         byte_idx   <= '0;
         asm_word   <= '0;
         last_word  <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (accept) begin
                  if (full) begin
                     // Memory is full: drop the byte, flag it, keep draining the source.
                     err <= 1'b1;
                     if (in_last) state <= S_DONE;
                  end else begin
                     asm_word <= merged;
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == 2'd3 || in_last) begin
                        we        <= 1'b1;
                        waddr     <= word_count[ADDR_WIDTH-1:0];
                        wdata     <= merged;
                        last_word <= in_last;
                        state     <= S_WRITE;
                     end
                  end
               end
            end
            S_WRITE: begin
               we         <= 1'b0;
               word_count <= word_count + 1'b1;
               asm_word   <= '0;
               byte_idx   <= '0;
               last_word  <= 1'b0;
               state      <= last_word ? S_DONE : S_LOAD;
            end
            S_DONE: begin
               if (start) begin
                  state      <= S_LOAD;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  core_rst   <= 1'b1;
                  err        <= 1'b0;
                  word_count <= '0;
                  waddr      <= '0;
                  wdata      <= '0;
                  asm_word   <= '0;
                  byte_idx   <= '0;
               end else begin
                  // Release the core one cycle after the final write retires.
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  core_rst <= 1'b0;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running sum of every word written during this load, cleared on restart.
   always_ff @(posedge clk) begin
      if (rst)
         checksum <= '0;
      else if (state == S_WRITE)
         checksum <= checksum + wdata;
      else if (state == S_DONE && start)
         checksum <= '0;
   end
`else
   assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (full-size and a 2-word memory) driven
// with directed and random byte streams, checked against a word-level model.
module tb_imem_loader;

   localparam int AW   = 14;
   localparam int CAPA = 16384;
   localparam int CAPB = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_v [2];
   logic        vld_v   [2];
   logic [7:0]  din_v   [2];
   logic        last_v  [2];
   logic        rdy_v   [2];
   logic        we_v    [2];
   logic [AW-1:0] waddr_v [2];
   logic [31:0] wdata_v [2];
   logic        busy_v  [2];
   logic        done_v  [2];
   logic        crst_v  [2];
   logic        err_v   [2];
   logic [AW:0] wc_v    [2];
   logic [31:0] cks_v   [2];

   int vec = 0;
   int bad = 0;
   int ovl = 0;
   logic [AW+31:0] wlog0 [$];
   logic [AW+31:0] wlog1 [$];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(CAPA)) dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(vld_v[0]), .in_data(din_v[0]),
      .in_last(last_v[0]), .in_ready(rdy_v[0]), .we(we_v[0]), .waddr(waddr_v[0]),
      .wdata(wdata_v[0]), .busy(busy_v[0]), .done(done_v[0]), .core_rst(crst_v[0]),
      .err(err_v[0]), .word_count(wc_v[0]), .checksum(cks_v[0]));

   imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(CAPB)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(vld_v[1]), .in_data(din_v[1]),
      .in_last(last_v[1]), .in_ready(rdy_v[1]), .we(we_v[1]), .waddr(waddr_v[1]),
      .wdata(wdata_v[1]), .busy(busy_v[1]), .done(done_v[1]), .core_rst(crst_v[1]),
      .err(err_v[1]), .word_count(wc_v[1]), .checksum(cks_v[1]));

   // Write monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (we_v[0] === 1'b1) wlog0.push_back({waddr_v[0], wdata_v[0]});
      if (we_v[1] === 1'b1) wlog1.push_back({waddr_v[1], wdata_v[1]});
      if (we_v[0] === 1'b1 && rdy_v[0] === 1'b1) ovl++;
      if (we_v[1] === 1'b1 && rdy_v[1] === 1'b1) ovl++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: split the stream into 4-byte little-endian words, keep the first cap.
   task automatic model(input logic [7:0] q[$], input int cap,
                        output logic [31:0] words[$], output logic [31:0] sum, output logic e);
      int nb = q.size();
      int nw = (nb + 3) / 4;
      words = {};
      sum = 0;
      for (int w = 0; w < nw && w < cap; w++) begin
         logic [31:0] x = 0;
         for (int k = 0; k < 4; k++)
            if (4*w + k < nb) x = x | (32'(q[4*w + k]) << (8*k));
         words.push_back(x);
         sum = sum + x;
      end
      e = (nb > 4*cap);
   endtask

   task automatic restart(input int sel);
      @(negedge clk); start_v[sel] = 1'b1;
      @(negedge clk); start_v[sel] = 1'b0;
      chk("rs_busy",  busy_v[sel], 1);
      chk("rs_done",  done_v[sel], 0);
      chk("rs_crst",  crst_v[sel], 1);
      chk("rs_err",   err_v[sel], 0);
      chk("rs_wc",    wc_v[sel], 0);
      chk("rs_cks",   cks_v[sel], 0);
      chk("rs_waddr", waddr_v[sel], 0);
      chk("rs_wdata", wdata_v[sel], 0);
   endtask

   task automatic run_load(input int sel, input logic [7:0] q[$], input int vprob, input int cap);
      logic [31:0] words [$];
      logic [31:0] sum;
      logic        e;
      logic [AW+31:0] got [$];
      logic acc_prev = 1'b0;
      int k = 0;
      int waitc = 0;
      int n = q.size();
      if (done_v[sel] === 1'b1) restart(sel);
      if (sel == 0) wlog0 = {}; else wlog1 = {};
      model(q, cap, words, sum, e);
      while (k < n) begin
         @(negedge clk);
         if (acc_prev) begin
            chk("err_trk", err_v[sel], (k > 4*cap));
            chk("crst_load", crst_v[sel], 1);
            if (k > 4*cap) chk("drain_rdy", rdy_v[sel], 1);
         end
         if (waitc > 200) begin
            chk("byte_timeout", 0, 1);
            vld_v[sel] = 1'b0;
            return;
         end
         vld_v[sel]   = ($urandom_range(99) < vprob);
         din_v[sel]   = q[k];
         last_v[sel]  = (k == n-1);
         start_v[sel] = ($urandom_range(7) == 0);
         acc_prev = vld_v[sel] && (rdy_v[sel] === 1'b1);
         if (acc_prev) begin k++; waitc = 0; end
         else waitc++;
      end
      // last byte accepted at the coming edge N
      @(negedge clk);
      vld_v[sel] = 1'b0; last_v[sel] = 1'b0; start_v[sel] = 1'b0;
      din_v[sel] = $urandom_range(255);
      chk("err_last", err_v[sel], e);
      chk("we_last", we_v[sel], !e);
      @(negedge clk);
      chk("done_n1", done_v[sel], e);
      @(negedge clk);
      chk("done_n2", done_v[sel], 1);
      chk("crst_n2", crst_v[sel], 0);
      chk("busy_n2", busy_v[sel], 0);
      got = (sel == 0) ? wlog0 : wlog1;
      chk("nwrites", got.size(), words.size());
      for (int i = 0; i < words.size() && i < got.size(); i++) begin
         chk("waddr", got[i][AW+31:32], i);
         chk("wdata", got[i][31:0], words[i]);
      end
      chk("wcount", wc_v[sel], words.size());
`ifdef LOADER_CHECKSUM_EN
      chk("cksum", cks_v[sel], sum);
`else
      chk("cksum", cks_v[sel], 0);
`endif
      chk("err_final", err_v[sel], e);
   endtask

   initial begin
      logic [7:0] q [$];
      for (int s = 0; s < 2; s++) begin
         start_v[s] = 1'b0; vld_v[s] = 1'b0; din_v[s] = 8'h0; last_v[s] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_rdy_a", rdy_v[0], 0);
      chk("rst_rdy_b", rdy_v[1], 0);
      chk("rst_we",    we_v[0], 0);
      chk("rst_waddr", waddr_v[0], 0);
      chk("rst_wdata", wdata_v[0], 0);
      chk("rst_busy",  busy_v[0], 1);
      chk("rst_done",  done_v[0], 0);
      chk("rst_crst",  crst_v[0], 1);
      chk("rst_err",   err_v[0], 0);
      chk("rst_wc",    wc_v[0], 0);
      chk("rst_cks",   cks_v[0], 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", rdy_v[0], 1);

      // Two-word program
      q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load(0, q, 100, CAPA);
      // Partial last word
      q = {8'h13, 8'h00, 8'h00, 8'h00, 8'hAA};
      run_load(0, q, 100, CAPA);
      // Same two-word program with gappy valid
      q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load(0, q, 50, CAPA);

      // Reset in the middle of a word
      restart(0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); vld_v[0] = 1'b1; din_v[0] = 8'hC0 + 8'(i); last_v[0] = 1'b0;
      end
      @(negedge clk); vld_v[0] = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("midrst_rdy", rdy_v[0], 0);
      rst = 1'b0;
      q = {8'h01, 8'h02, 8'h03, 8'h04};
      run_load(0, q, 100, CAPA);

      // Reload from DONE
      q = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_load(0, q, 100, CAPA);

      // Overflow on the 2-word memory
      q = {};
      for (int i = 0; i < 12; i++) q.push_back(8'($urandom_range(255)));
      run_load(1, q, 100, CAPB);
      // Exactly full, no overflow
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom_range(255)));
      run_load(1, q, 70, CAPB);
      for (int t = 0; t < 4; t++) begin
         q = {};
         for (int i = 0; i < int'($urandom_range(20, 1)); i++) q.push_back(8'($urandom_range(255)));
         run_load(1, q, 60, CAPB);
      end

      // Random programs on the full-size memory
      for (int t = 0; t < 6; t++) begin
         q = {};
         for (int i = 0; i < int'($urandom_range(40, 1)); i++) q.push_back(8'($urandom_range(255)));
         run_load(0, q, int'($urandom_range(100, 30)), CAPA);
      end

      chk("we_vs_ready", ovl, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
